// File: rtl/accumulator_16bit_if.sv
// Sample-in / block-result-out bundle for accumulator_16bit.
// The slave modport is the accumulator side; master is the sample source and consumer.
interface accumulator_16bit_if;
    logic        clear;
    logic [15:0] data_in;
    logic        data_valid;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic        overflow_flag;
    logic [7:0]  sample_count;

    modport slave (
        input  clear, data_in, data_valid,
        output busy, result, result_valid, overflow_flag, sample_count
    );

    modport master (
        output clear, data_in, data_valid,
        input  busy, result, result_valid, overflow_flag, sample_count
    );
endinterface

// File: rtl/accumulator_16bit.sv
// Block accumulator: sums NUM_SAMPLES unsigned 16-bit samples through a ripple-carry
// adder and publishes the total with a one-cycle strobe and a sticky carry-out flag.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module adder_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        carry_i,
    output logic [15:0] sum_o,
    output logic        overflow_o
);
    logic [16:0] carry;

    assign carry[0]   = carry_i;
    assign overflow_o = carry[16];

    full_adder_cell u_fa [15:0] (
        .a_i (a_i),
        .b_i (b_i),
        .c_i (carry[15:0]),
        .s_o (sum_o),
        .c_o (carry[16:1])
    );
endmodule

module accumulator_16bit #(
    parameter int NUM_SAMPLES = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    accumulator_16bit_if.slave  bus
);
    if (NUM_SAMPLES < 2 || NUM_SAMPLES > 255) begin : g_bad_param
        $error("accumulator_16bit: NUM_SAMPLES must be in 2..255");
    end

    localparam logic [7:0] LAST_IDX = 8'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [15:0] result_q, result_d;
    logic        oflag_q, oflag_d;

    logic [15:0] sum;
    logic        carry_out;
    logic        last_sample;

    // acc_q is held at zero outside ACCUM, so IDLE's "0 + data_in" shares this adder.
    adder_16bit u_adder (
        .a_i        (acc_q),
        .b_i        (bus.data_in),
        .carry_i    (1'b0),
        .sum_o      (sum),
        .overflow_o (carry_out)
    );

    assign last_sample = bus.data_valid && (count_q == LAST_IDX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.data_valid) state_d = ACCUM;
                ACCUM:   if (last_sample) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy         = (state_q == DONE);
        bus.result_valid = (state_q == DONE);
    end

    always_comb begin
        acc_d    = acc_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        oflag_d  = oflag_q;
        if (bus.clear) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.data_valid) begin
                        acc_d   = sum;
                        count_d = 8'd1;
                        ovf_d   = 1'b0;
                    end
                end
                ACCUM: begin
                    if (bus.data_valid) begin
                        acc_d   = sum;
                        count_d = count_q + 8'd1;
                        ovf_d   = ovf_q | carry_out;
                    end
                    // Publish on the completing edge so DONE already shows the new total.
                    if (last_sample) begin
                        result_d = sum;
                        oflag_d  = ovf_q | carry_out;
                    end
                end
                default: begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            oflag_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            oflag_q  <= oflag_d;
        end
    end

    assign bus.result        = result_q;
    assign bus.overflow_flag = oflag_q;
    assign bus.sample_count  = count_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (n_rst && bus.data_valid) begin
            assert (!$isunknown(bus.data_in))
                else $error("accumulator_16bit: data_in has X/Z while data_valid=1");
        end
    end
`endif
endmodule

// File: tb/tb_accumulator_16bit.sv
// Scoreboarded bench for accumulator_16bit: three instances (8, 2, 4 samples per block);
// expected block results are queued as stimulus is driven and popped on result_valid.
module tb_accumulator_16bit;
    logic clk;
    logic n_rst;
    int   checks;
    int   errors;

    accumulator_16bit_if a8();
    accumulator_16bit_if a2();
    accumulator_16bit_if a4();

    accumulator_16bit #(.NUM_SAMPLES(8)) u8 (.clk(clk), .n_rst(n_rst), .bus(a8.slave));
    accumulator_16bit #(.NUM_SAMPLES(2)) u2 (.clk(clk), .n_rst(n_rst), .bus(a2.slave));
    accumulator_16bit #(.NUM_SAMPLES(4)) u4 (.clk(clk), .n_rst(n_rst), .bus(a4.slave));

    // {overflow_flag, result}
    logic [16:0] q8[$];
    logic [16:0] q2[$];
    logic [16:0] q4[$];
    logic [16:0] e8, e2, e4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (n_rst && a8.result_valid) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL n8_unexpected_result: got result_valid with result=%h, none expected", a8.result);
            end else begin
                e8 = q8.pop_front();
                if ({a8.overflow_flag, a8.result} !== e8) begin
                    errors++;
                    $display("FAIL n8_result: got ovf=%b result=%h, expected ovf=%b result=%h",
                             a8.overflow_flag, a8.result, e8[16], e8[15:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (n_rst && a2.result_valid) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL n2_unexpected_result: got result_valid with result=%h, none expected", a2.result);
            end else begin
                e2 = q2.pop_front();
                if ({a2.overflow_flag, a2.result} !== e2) begin
                    errors++;
                    $display("FAIL n2_result: got ovf=%b result=%h, expected ovf=%b result=%h",
                             a2.overflow_flag, a2.result, e2[16], e2[15:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (n_rst && a4.result_valid) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL n4_unexpected_result: got result_valid with result=%h, none expected", a4.result);
            end else begin
                e4 = q4.pop_front();
                if ({a4.overflow_flag, a4.result} !== e4) begin
                    errors++;
                    $display("FAIL n4_result: got ovf=%b result=%h, expected ovf=%b result=%h",
                             a4.overflow_flag, a4.result, e4[16], e4[15:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #12;
        checks++;
        if ({a8.busy, a8.result, a8.result_valid, a8.overflow_flag, a8.sample_count} !== 27'd0) begin
            errors++;
            $display("FAIL reset_n8: got busy=%b result=%h rv=%b ovf=%b cnt=%0d, expected all 0",
                     a8.busy, a8.result, a8.result_valid, a8.overflow_flag, a8.sample_count);
        end
        checks++;
        if ({a2.busy, a2.result, a2.result_valid, a2.overflow_flag, a2.sample_count} !== 27'd0) begin
            errors++;
            $display("FAIL reset_n2: got busy=%b result=%h rv=%b ovf=%b cnt=%0d, expected all 0",
                     a2.busy, a2.result, a2.result_valid, a2.overflow_flag, a2.sample_count);
        end
        checks++;
        if ({a4.busy, a4.result, a4.result_valid, a4.overflow_flag, a4.sample_count} !== 27'd0) begin
            errors++;
            $display("FAIL reset_n4: got busy=%b result=%h rv=%b ovf=%b cnt=%0d, expected all 0",
                     a4.busy, a4.result, a4.result_valid, a4.overflow_flag, a4.sample_count);
        end
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_basic_sum();
        logic [16:0] tot;
        tot = '0;
        for (int k = 1; k <= 8; k++) tot += 17'(k);
        q8.push_back({1'b0, tot[15:0]});
        for (int k = 1; k <= 8; k++) begin
            a8.data_valid = 1'b1;
            a8.data_in    = 16'(k);
            step();
        end
        a8.data_valid = 1'b0;
        // now in the cycle after sample 8
        checks++;
        if (a8.result_valid !== 1'b1 || a8.busy !== 1'b1 || a8.sample_count !== 8'd8) begin
            errors++;
            $display("FAIL basic_done: got rv=%b busy=%b cnt=%0d, expected rv=1 busy=1 cnt=8",
                     a8.result_valid, a8.busy, a8.sample_count);
        end
        step();
        checks++;
        if (a8.result_valid !== 1'b0 || a8.busy !== 1'b0 || a8.sample_count !== 8'd0 || a8.result !== 16'h0024) begin
            errors++;
            $display("FAIL basic_after: got rv=%b busy=%b cnt=%0d result=%h, expected rv=0 busy=0 cnt=0 result=0024",
                     a8.result_valid, a8.busy, a8.sample_count, a8.result);
        end
    endtask

    task automatic test_overflow();
        q2.push_back({1'b1, 16'h0001});
        a2.data_valid = 1'b1;
        a2.data_in = 16'hFFFF; step();
        a2.data_in = 16'h0002; step();
        a2.data_valid = 1'b0;
        step();
        q2.push_back({1'b0, 16'h0002});
        a2.data_valid = 1'b1;
        a2.data_in = 16'h0001; step();
        a2.data_in = 16'h0001; step();
        a2.data_valid = 1'b0;
        step();
        checks++;
        if (a2.overflow_flag !== 1'b0 || a2.result !== 16'h0002) begin
            errors++;
            $display("FAIL overflow_held: got ovf=%b result=%h, expected ovf=0 result=0002",
                     a2.overflow_flag, a2.result);
        end
    endtask

    task automatic test_gapped_done_drop();
        q4.push_back({1'b0, 16'h4000});
        for (int k = 0; k < 4; k++) begin
            a4.data_valid = 1'b1;
            a4.data_in    = 16'h1000;
            step();
            a4.data_valid = 1'b0;
            if (k < 3) repeat (3) step();
        end
        checks++;
        if (a4.result_valid !== 1'b1) begin
            errors++;
            $display("FAIL gapped_done: got rv=%b, expected 1", a4.result_valid);
        end
        a4.data_valid = 1'b1;
        a4.data_in    = 16'h7777;
        step();
        a4.data_valid = 1'b0;
        checks++;
        if (a4.sample_count !== 8'd0 || a4.result !== 16'h4000) begin
            errors++;
            $display("FAIL gapped_drop: got cnt=%0d result=%h, expected cnt=0 result=4000",
                     a4.sample_count, a4.result);
        end
        step();
    endtask

    task automatic test_clear();
        a4.data_valid = 1'b1;
        a4.data_in = 16'd10; step();
        a4.data_in = 16'd20; step();
        a4.data_in = 16'd30;
        a4.clear   = 1'b1;
        step();
        a4.clear      = 1'b0;
        a4.data_valid = 1'b0;
        checks++;
        if (a4.sample_count !== 8'd0 || a4.result !== 16'h4000 || a4.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_abort: got cnt=%0d result=%h rv=%b, expected cnt=0 result=4000 rv=0",
                     a4.sample_count, a4.result, a4.result_valid);
        end
        step();
        q4.push_back({1'b0, 16'h0004});
        for (int k = 0; k < 4; k++) begin
            a4.data_valid = 1'b1;
            a4.data_in    = 16'h0001;
            if (k == 3) begin
                checks++;
                if (a4.result !== 16'h4000) begin
                    errors++;
                    $display("FAIL clear_result_held: got result=%h, expected 4000", a4.result);
                end
            end
            step();
        end
        a4.data_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            a8.data_valid = 1'b1;
            a8.data_in    = 16'h0100;
            step();
        end
        a8.data_valid = 1'b0;
        checks++;
        if (a8.sample_count !== 8'd3) begin
            errors++;
            $display("FAIL async_pre: got cnt=%0d, expected 3", a8.sample_count);
        end
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({a8.busy, a8.result, a8.result_valid, a8.overflow_flag, a8.sample_count} !== 27'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b result=%h rv=%b ovf=%b cnt=%0d, expected all 0",
                     a8.busy, a8.result, a8.result_valid, a8.overflow_flag, a8.sample_count);
        end
        n_rst = 1'b1;
        step();
        q8.push_back({1'b0, 16'h0010});
        for (int k = 0; k < 8; k++) begin
            a8.data_valid = 1'b1;
            a8.data_in    = 16'h0002;
            step();
        end
        a8.data_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [5];
        vals = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        // 7 lands in the DONE cycle and is dropped: 5+6, then 8+9
        q2.push_back({1'b0, 16'h000B});
        q2.push_back({1'b0, 16'h0011});
        for (int k = 0; k < 5; k++) begin
            a2.data_valid = 1'b1;
            a2.data_in    = vals[k];
            step();
        end
        a2.data_valid = 1'b0;
        checks++;
        if (a2.result_valid !== 1'b1 || a2.result !== 16'h0011) begin
            errors++;
            $display("FAIL b2b_second: got rv=%b result=%h, expected rv=1 result=0011",
                     a2.result_valid, a2.result);
        end
        step();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_rst  = 1'b0;
        a8.clear = 1'b0; a8.data_in = '0; a8.data_valid = 1'b0;
        a2.clear = 1'b0; a2.data_in = '0; a2.data_valid = 1'b0;
        a4.clear = 1'b0; a4.data_in = '0; a4.data_valid = 1'b0;

        test_reset();
        test_basic_sum();
        test_overflow();
        test_gapped_done_drop();
        test_clear();
        test_async_reset();
        test_back_to_back();

        checks++;
        if (q8.size() != 0 || q2.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL missing_results: got pending n8=%0d n2=%0d n4=%0d, expected 0 0 0",
                     q8.size(), q2.size(), q4.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
